// File: rtl/reg_bypass_scoreboard_if.sv
// reg_bypass_scoreboard_if
//   Bundles the operand-read, forwarding, write-back and long-latency issue
//   signals of the register read stage.
//   master : ID / pipeline side (drives requests and forwarding, samples operands)
//   slave  : the register read stage itself
// Vectors are packed flat: element k lives at [k*W +: W].
interface reg_bypass_scoreboard_if #(
    parameter int READ_PORTS = 2,
    parameter int FWD_STAGES = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [READ_PORTS-1:0]            read_en;
    logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr;
    logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [READ_PORTS-1:0]            read_stall;
    logic                             stall;

    logic [FWD_STAGES-1:0]            fwd_en;
    logic [FWD_STAGES-1:0]            fwd_ready;
    logic [FWD_STAGES*ADDR_WIDTH-1:0] fwd_addr;
    logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_data;

    logic                             wb_en;
    logic [ADDR_WIDTH-1:0]            wb_addr;
    logic [DATA_WIDTH-1:0]            wb_data;
    logic                             wb_long;

    logic                             issue_en;
    logic [ADDR_WIDTH-1:0]            issue_addr;
    logic                             issue_conflict;
    logic [31:0]                      stall_count;

    modport master (
        output read_en, read_addr, fwd_en, fwd_ready, fwd_addr, fwd_data,
               wb_en, wb_addr, wb_data, wb_long, issue_en, issue_addr,
        input  read_data, read_stall, stall, issue_conflict, stall_count
    );

    modport slave (
        input  read_en, read_addr, fwd_en, fwd_ready, fwd_addr, fwd_data,
               wb_en, wb_addr, wb_data, wb_long, issue_en, issue_addr,
        output read_data, read_stall, stall, issue_conflict, stall_count
    );
endinterface

// File: rtl/reg_bypass_scoreboard.sv
// reg_bypass_scoreboard
//   Register-file read stage: architectural register array (r0 == 0),
//   READ_PORTS combinational operand reads with forwarding from FWD_STAGES
//   pipeline stages and the write-back port, plus a one-bit-per-register
//   scoreboard of outstanding long-latency producers.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - reg_bypass_scoreboard_if.slave (reads, forwarding, write-back,
//          long-latency issue, stall / conflict / stall_count outputs)
module reg_bypass_scoreboard #(
    parameter int READ_PORTS = 2,
    parameter int FWD_STAGES = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    reg_bypass_scoreboard_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [31:0]           stall_cnt;
    logic                  wb_clr;
    logic                  issue_set;

    // ---------------- operand read ports ----------------
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] d;
        logic                  s;

        assign ra = bus.read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Sources are layered lowest priority first so later assignments win:
        // array/scoreboard, then write-back, then forwarding stages from oldest
        // to youngest (the youngest matching stage wins).
        always_comb begin
            d = '0;
            s = 1'b0;
            if (bus.read_en[p] && ra != '0) begin
                d = regs[ra];
                s = pending[ra];
                if (bus.wb_en && bus.wb_addr == ra) begin
                    d = bus.wb_data;
                    s = 1'b0;
                end
                for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                    if (bus.fwd_en[i] && bus.fwd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra) begin
                        d = bus.fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
                        s = ~bus.fwd_ready[i];
                    end
                end
            end
        end

        assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
        assign bus.read_stall[p] = s;
    end

    assign bus.stall = |bus.read_stall;

    // ---------------- scoreboard ----------------
    assign wb_clr = bus.wb_en && bus.wb_long;

    // Conflict is judged against the pre-clear state; a retiring write to
    // the same register frees the slot for the new producer this cycle.
    assign bus.issue_conflict = bus.issue_en && bus.issue_addr != '0 &&
                                pending[bus.issue_addr] &&
                                !(wb_clr && bus.wb_addr == bus.issue_addr);

    assign issue_set = bus.issue_en && bus.issue_addr != '0 && !bus.issue_conflict;

    // Clear first, then set, so a same-register clear+set leaves it pending.
    always_comb begin
        pending_next = pending;
        if (wb_clr)
            pending_next[bus.wb_addr] = 1'b0;
        if (issue_set)
            pending_next[bus.issue_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                regs[k] <= '0;
            pending   <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.wb_en && bus.wb_addr != '0)
                regs[bus.wb_addr] <= bus.wb_data;
            pending <= pending_next;
            if (bus.stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_reg_bypass_scoreboard.sv
// Bench for reg_bypass_scoreboard: directed vectors, expected values pushed
// into a queue by the stimulus and popped/compared by a monitor at negedge.
module tb_reg_bypass_scoreboard;
    localparam int RP = 2, FS = 2, DW = 32, AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bypass_scoreboard_if #(.READ_PORTS(RP), .FWD_STAGES(FS),
                               .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_bypass_scoreboard #(.READ_PORTS(RP), .FWD_STAGES(FS),
                            .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        bit          chk_d0;
        logic [1:0]  st;
        logic        cf;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: the outputs are combinational, so each queued expectation
    // is checked at the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_d0)
                cmp(e.name, "rd0", bus.read_data[0 +: DW], e.d0);
            cmp(e.name, "rd1", bus.read_data[DW +: DW], e.d1);
            cmp(e.name, "read_stall", {30'd0, bus.read_stall}, {30'd0, e.st});
            cmp(e.name, "stall", {31'd0, bus.stall}, {31'd0, |e.st});
            cmp(e.name, "conflict", {31'd0, bus.issue_conflict}, {31'd0, e.cf});
            cmp(e.name, "stall_count", bus.stall_count, e.cnt);
        end
    end

    task automatic idle();
        bus.read_en = '0; bus.read_addr = '0;
        bus.fwd_en = '0; bus.fwd_ready = '0; bus.fwd_addr = '0; bus.fwd_data = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0; bus.wb_long = 1'b0;
        bus.issue_en = 1'b0; bus.issue_addr = '0;
    endtask

    task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        bus.read_en = en;
        bus.read_addr[0 +: AW] = a0;
        bus.read_addr[AW +: AW] = a1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic lng);
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d; bus.wb_long = lng;
    endtask

    task automatic iss(input logic [4:0] a);
        bus.issue_en = 1'b1; bus.issue_addr = a;
    endtask

    // Queue the expectation, let the monitor check it, advance one edge.
    task automatic step(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] st, input logic cf, input logic [31:0] cnt,
                        input bit chk_d0 = 1'b1);
        exp_t e;
        e.name = nm; e.d0 = d0; e.d1 = d1; e.chk_d0 = chk_d0;
        e.st = st; e.cf = cf; e.cnt = cnt;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b1;
        step("in_reset", 0, 0, 2'b00, 0, 0);
        step("in_reset2", 0, 0, 2'b00, 0, 0);
        rst = 1'b0;

        // reads disabled, addresses r5/r0
        idle(); rd(2'b00, 5'd5, 5'd0);
        step("post_reset", 0, 0, 2'b00, 0, 0);

        // write-back bypass, then array
        idle(); rd(2'b11, 5'd3, 5'd3); wb(5'd3, 32'h1234, 1'b0);
        step("wb_bypass", 32'h1234, 32'h1234, 2'b00, 0, 0);
        idle(); rd(2'b11, 5'd3, 5'd3);
        step("array_r3", 32'h1234, 32'h1234, 2'b00, 0, 0);

        // forwarding: youngest matching stage wins
        idle(); rd(2'b11, 5'd7, 5'd3);
        bus.fwd_en = 2'b11; bus.fwd_ready = 2'b11;
        bus.fwd_addr[0 +: AW] = 5'd7; bus.fwd_addr[AW +: AW] = 5'd7;
        bus.fwd_data[0 +: DW] = 32'hAAAA; bus.fwd_data[DW +: DW] = 32'hBBBB;
        step("fwd_young", 32'hAAAA, 32'h1234, 2'b00, 0, 0);
        bus.fwd_ready = 2'b10;
        step("fwd_load0", 32'hAAAA, 32'h1234, 2'b01, 0, 0);
        step("fwd_load1", 32'hAAAA, 32'h1234, 2'b01, 0, 1);
        step("fwd_load2", 32'hAAAA, 32'h1234, 2'b01, 0, 2);
        bus.fwd_en = 2'b10;
        step("fwd_old", 32'hBBBB, 32'h1234, 2'b00, 0, 3);

        // long-latency scoreboard on r9
        idle(); rd(2'b11, 5'd9, 5'd3); iss(5'd9);
        step("issue_r9", 0, 32'h1234, 2'b00, 0, 3);
        idle(); rd(2'b11, 5'd9, 5'd3); iss(5'd9);
        step("conflict_r9", 0, 32'h1234, 2'b01, 1, 3, 1'b0);
        idle(); rd(2'b11, 5'd9, 5'd3); iss(5'd9); wb(5'd9, 32'h55, 1'b1);
        step("retire_reissue", 32'h55, 32'h1234, 2'b00, 0, 4);
        idle(); rd(2'b11, 5'd9, 5'd3);
        step("still_pending", 0, 32'h1234, 2'b01, 0, 4, 1'b0);
        idle(); rd(2'b11, 5'd9, 5'd3); wb(5'd9, 32'h66, 1'b1);
        step("retire_r9", 32'h66, 32'h1234, 2'b00, 0, 5);
        idle(); rd(2'b11, 5'd9, 5'd3);
        step("r9_clear", 32'h66, 32'h1234, 2'b00, 0, 5);

        // r0: no pending, no write, forwarding ignored
        idle(); rd(2'b11, 5'd0, 5'd0); iss(5'd0); wb(5'd0, 32'hFFFF, 1'b0);
        bus.fwd_en = 2'b01; bus.fwd_ready = 2'b00;
        bus.fwd_addr[0 +: AW] = 5'd0; bus.fwd_data[0 +: DW] = 32'h77;
        step("r0_writes", 0, 0, 2'b00, 0, 5);
        idle(); rd(2'b11, 5'd0, 5'd0);
        step("r0_read", 0, 0, 2'b00, 0, 5);

        // wb_long to a non-pending register
        idle(); rd(2'b11, 5'd10, 5'd3); wb(5'd10, 32'hABC, 1'b1);
        step("long_nonpend", 32'hABC, 32'h1234, 2'b00, 0, 5);
        idle(); rd(2'b11, 5'd10, 5'd3);
        step("r10_array", 32'hABC, 32'h1234, 2'b00, 0, 5);

        // pending r4, then async reset mid-stall
        idle(); rd(2'b11, 5'd4, 5'd3); iss(5'd4);
        step("issue_r4", 0, 32'h1234, 2'b00, 0, 5);
        idle(); rd(2'b11, 5'd4, 5'd3);
        step("r4_stall0", 0, 32'h1234, 2'b01, 0, 5, 1'b0);
        step("r4_stall1", 0, 32'h1234, 2'b01, 0, 6, 1'b0);
        rst = 1'b1;
        step("async_rst", 0, 0, 2'b00, 0, 0);
        rst = 1'b0;
        step("after_rst", 0, 0, 2'b00, 0, 0);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_bypass_scoreboard.md
# reg_bypass_scoreboard

Parametrised register-file read stage with operand bypassing and a long-latency scoreboard. It sits between ID and the pipeline and holds the architectural register array (r0 hardwired to zero). It serves READ_PORTS operand reads per cycle, forwarding from FWD_STAGES in-flight pipeline stages and from the write-back port. It tracks outstanding long-latency producers (loads, mul/div) so that ID stalls until their results exist.

## Interface
- READ_PORTS, 2, number of operand read ports
- FWD_STAGES, 2, number of forwarding sources; index 0 is youngest (EX), higher is older
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width; array depth 2^ADDR_WIDTH
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- read_en  in  READ_PORTS  per-port read enable
- read_addr  in  READ_PORTS*ADDR_WIDTH  port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  READ_PORTS*DATA_WIDTH  operand per port, same packing
- read_stall  out  READ_PORTS  port p operand not yet available
- stall  out  1  OR of read_stall
- fwd_en  in  FWD_STAGES  stage i will write a register
- fwd_ready  in  FWD_STAGES  stage i result already valid; 0 marks a load in EX
- fwd_addr  in  FWD_STAGES*ADDR_WIDTH  destination of stage i
- fwd_data  in  FWD_STAGES*DATA_WIDTH  result of stage i
- wb_en, wb_addr, wb_data  in  1/ADDR_WIDTH/DATA_WIDTH  write-back port
- wb_long  in  1  this write retires a long-latency producer
- issue_en  in  1  a long-latency producer issues this cycle
- issue_addr  in  ADDR_WIDTH  its destination
- issue_conflict  out  1  issue_addr is already pending; issuer must stall
- stall_count  out  32  saturating count of cycles with stall=1

## Operation
- Array: 2^ADDR_WIDTH x DATA_WIDTH. On wb_en with wb_addr!=0, write wb_data at the clock edge. Address 0 always reads 0 and is never written.
- Per-port read mux (combinational), with priority highest first:
  1. read_en=0 -> data 0, no stall.
  2. read_addr=0 -> data 0, no stall. This applies even if a stage targets r0.
  3. Find the lowest i with fwd_en[i] && fwd_addr[i]==read_addr. Use fwd_data[i]. Stall if fwd_ready[i]=0. Older matching stages are ignored.
  4. If wb_en && wb_addr==read_addr, use wb_data (write-first bypass).
  5. If pending[read_addr]=1, stall. data is don't-care but driven from the array.
  6. Otherwise use the array.
- Scoreboard: one pending bit per register. No more than one long-latency producer is outstanding per register.
  - Set: issue_en && issue_addr!=0 && !issue_conflict.
  - Clear: wb_en && wb_long && wb_addr matches.
  - Set and clear of the same register in one cycle: the clear retires the old producer and the set records the new one, so the result is pending=1. issue_conflict is evaluated against the pre-clear value and is suppressed when the same-cycle clear matches.
- issue_conflict = issue_en && issue_addr!=0 && pending[issue_addr] && !(wb_en && wb_long && wb_addr==issue_addr).
- A wb_long write to a non-pending register writes the array normally; the pending bit stays 0.
- stall_count increments when stall=1 and holds at 0xFFFF_FFFF.

## Timing
- Reads, stalls and issue_conflict are combinational, with zero latency.
- Array write is visible from the array at t+1. At cycle t it is visible only through the bypass.
- A pending set at edge t is visible at t+1. A clear at edge t is visible at t+1, but the same-cycle wb bypass (step 4) already supplies the data at t, so there is no stall at t.
- Reset (async assert, any time including mid-stall):
  - array = 0, pending = 0, stall_count = 0
  - outputs become their combinational function of the cleared state: read_data = 0 unless forwarded, read_stall = 0 unless a fwd_ready=0 match
  - the release edge behaves as a normal first cycle

## Test plan
- After reset, read ports 0/1 at r5/r0 with all enables low -> read_data=0/0, stall=0, stall_count=0.
- wb writes r3=0x1234 at t; port0 reads r3 at t -> 0x1234 via bypass. At t+1 the array read gives 0x1234.
- fwd stage0 and stage1 both target r7 (0xAAAA, 0xBBBB), fwd_ready=1 -> 0xAAAA. Then stage0 fwd_ready=0 -> read_stall[0]=1, stall_count increments each cycle.
- Issue long to r9. Reading r9 stalls. A second issue to r9 gives issue_conflict=1. wb r9=0x55 with wb_long in the same cycle as a new issue to r9 -> no conflict, read returns 0x55 with no stall that cycle, pending[r9]=1 afterwards.
- Issue to r0 and a wb to r0 with 0xFFFF -> no pending bit set, reads of r0 return 0, no stall.
- Pending r4 set; assert rst mid-stall -> pending cleared immediately, r4 reads 0 with no stall, stall_count=0.
